// File: rtl/alu_ctrl_issue.sv
// ============================================================================
// Module   : alu_ctrl_issue
// Brief    : ALUControl decode and ID/EX issue stage with a 2-entry skid buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_issue #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [DATA_W-1:0] in_srca,
  input  logic [DATA_W-1:0] in_srcb,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] out_srca,
  output logic [DATA_W-1:0] out_srcb,
  output logic [TAG_W-1:0]  out_rd,
  output logic              IllegalOp
);

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_SLTU = 4'b1000;
  localparam logic [3:0] c_ALU_XOR  = 4'b1001;
  localparam logic [3:0] c_ALU_SLL  = 4'b1010;
  localparam logic [3:0] c_ALU_SRL  = 4'b1011;
  localparam logic [3:0] c_ALU_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]        w_ctrl;
  logic              w_ill;
  logic              w_accept;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  logic [3:0]        r_m_ctrl, r_s_ctrl;
  logic              r_m_ill,  r_s_ill;
  logic [DATA_W-1:0] r_m_srca, r_s_srca;
  logic [DATA_W-1:0] r_m_srcb, r_s_srcb;
  logic [TAG_W-1:0]  r_m_rd,   r_s_rd;

  // Combinational decode of the incoming op
  always_comb begin
    w_ctrl = c_ALU_ADD;
    w_ill  = 1'b0;
    case (ALUOp)
      2'b00: w_ctrl = c_ALU_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: w_ctrl = c_ALU_SUB;
          3'b100, 3'b101: w_ctrl = c_ALU_SLT;
          3'b110, 3'b111: w_ctrl = c_ALU_SLTU;
          default: begin
            w_ctrl = c_ALU_ADD;
            w_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  w_ctrl = (ALUOp == 2'b10 && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b001:  w_ctrl = c_ALU_SLL;
          3'b010:  w_ctrl = c_ALU_SLT;
          3'b011:  w_ctrl = c_ALU_SLTU;
          3'b100:  w_ctrl = c_ALU_XOR;
          3'b101:  w_ctrl = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
          3'b110:  w_ctrl = c_ALU_OR;
          default: w_ctrl = c_ALU_AND;
        endcase
        // funct7b5 is only meaningful on R-type ADD/SUB and shifts
        if (ALUOp == 2'b10 && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101) begin
          w_ctrl = c_ALU_ADD;
          w_ill  = 1'b1;
        end
      end
    endcase
  end

  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && out_ready) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            w_state_nxt      = S_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_ctrl <= '0;
      r_m_ill  <= 1'b0;
      r_m_srca <= '0;
      r_m_srcb <= '0;
      r_m_rd   <= '0;
    end else if (w_load_main_in) begin
      r_m_ctrl <= w_ctrl;
      r_m_ill  <= w_ill;
      r_m_srca <= in_srca;
      r_m_srcb <= in_srcb;
      r_m_rd   <= in_rd;
    end else if (w_load_main_skid) begin
      r_m_ctrl <= r_s_ctrl;
      r_m_ill  <= r_s_ill;
      r_m_srca <= r_s_srca;
      r_m_srcb <= r_s_srcb;
      r_m_rd   <= r_s_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ctrl <= '0;
      r_s_ill  <= 1'b0;
      r_s_srca <= '0;
      r_s_srcb <= '0;
      r_s_rd   <= '0;
    end else if (w_load_skid) begin
      r_s_ctrl <= w_ctrl;
      r_s_ill  <= w_ill;
      r_s_srca <= in_srca;
      r_s_srcb <= in_srcb;
      r_s_rd   <= in_rd;
    end
  end

  assign ALUControl = r_m_ctrl;
  assign IllegalOp  = r_m_ill;
  assign out_srca   = r_m_srca;
  assign out_srcb   = r_m_srcb;
  assign out_rd     = r_m_rd;

endmodule

`default_nettype wire
